// File: rtl/nibble_serial_add_ctrl.sv
// Serial W-bit add/subtract controller driving one external 4-bit adder,
// one nibble per clock, least significant nibble first.
module nibble_serial_add_ctrl #(
   parameter int unsigned NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 sub,
   input  logic [4*NIBBLES-1:0] op_a,
   input  logic [4*NIBBLES-1:0] op_b,
   output logic                 ready,
   output logic                 done,
   output logic [4*NIBBLES-1:0] result,
   output logic                 carry_out,
   output logic                 overflow,
   output logic [3:0]           add_a,
   output logic [3:0]           add_b,
   output logic                 add_cin,
   input  logic [3:0]           add_sum,
   input  logic                 add_cout
);

   localparam int unsigned W    = 4 * NIBBLES;
   localparam int unsigned IDXW = $clog2(NIBBLES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic            cy_q, cy_d;
   logic [IDXW-1:0] idx_q, idx_d;
   logic [W-1:0]    result_q, result_d;
   logic            carry_q, carry_d;
   logic            ovf_q, ovf_d;

   logic            accept;
   logic            last_nib;

   assign accept   = (state_q == S_IDLE) && start;
   assign last_nib = (idx_q == IDXW'(NIBBLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (last_nib) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ready   = (state_q == S_IDLE);
      done    = (state_q == S_DONE);
      add_a   = '0;
      add_b   = '0;
      add_cin = 1'b0;
      if (state_q == S_RUN) begin
         add_a   = a_q[{idx_q, 2'b00} +: 4];
         add_b   = b_q[{idx_q, 2'b00} +: 4];
         add_cin = cy_q;
      end
   end

   // B is stored pre-inverted and the carry seeded with sub, so the adder
   // only ever sees an addition.
   always_comb begin
      a_d      = a_q;
      b_d      = b_q;
      cy_d     = cy_q;
      idx_d    = idx_q;
      result_d = result_q;
      carry_d  = carry_q;
      ovf_d    = ovf_q;
      if (accept) begin
         a_d      = op_a;
         b_d      = sub ? ~op_b : op_b;
         cy_d     = sub;
         idx_d    = '0;
         result_d = '0;
         carry_d  = 1'b0;
         ovf_d    = 1'b0;
      end else if (state_q == S_RUN) begin
         result_d[{idx_q, 2'b00} +: 4] = add_sum;
         cy_d = add_cout;
         if (last_nib) begin
            carry_d = add_cout;
            ovf_d   = (a_q[W-1] == b_q[W-1]) && (add_sum[3] != a_q[W-1]);
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q      <= '0;
         b_q      <= '0;
         cy_q     <= 1'b0;
         idx_q    <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         a_q      <= a_d;
         b_q      <= b_d;
         cy_q     <= cy_d;
         idx_q    <= idx_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         ovf_q    <= ovf_d;
      end
   end

   assign result    = result_q;
   assign carry_out = carry_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Scoreboard bench for nibble_serial_add_ctrl with a behavioural 4-bit adder.
module tb_nibble_serial_add_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        sub = 1'b0;
   logic [15:0] op_a = '0;
   logic [15:0] op_b = '0;
   logic        ready, done, carry_out, overflow;
   logic [15:0] result;
   logic [3:0]  add_a, add_b, add_sum;
   logic        add_cin, add_cout;

   int unsigned checks = 0;
   int unsigned failures = 0;
   int unsigned cyc = 0;

   typedef struct {
      logic [15:0] res;
      logic        cout;
      logic        ovf;
      int unsigned at;
   } exp_t;

   exp_t sb[$];

   nibble_serial_add_ctrl #(.NIBBLES(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .sub       (sub),
      .op_a      (op_a),
      .op_b      (op_b),
      .ready     (ready),
      .done      (done),
      .result    (result),
      .carry_out (carry_out),
      .overflow  (overflow),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_cin   (add_cin),
      .add_sum   (add_sum),
      .add_cout  (add_cout)
   );

   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && done) begin
         if (sb.size() == 0) begin
            check("done_unexpected", 32'(done), 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("result", 32'(result), 32'(e.res));
            check("carry_out", 32'(carry_out), 32'(e.cout));
            check("overflow", 32'(overflow), 32'(e.ovf));
            check("done_latency", cyc, e.at);
         end
      end
   end

   task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                           input bit push, input logic [15:0] r, input logic c, input logic o);
      exp_t e;
      bit   got;
      got = 0;
      @(negedge clk);
      op_a = a; op_b = b; sub = s; start = 1'b1;
      for (int i = 0; i < 20 && !got; i++) begin
         if (ready) got = 1;
         else @(negedge clk);
      end
      check("accept_ready", 32'(ready), 32'd1);
      @(posedge clk); #1;
      start = 1'b0;
      op_a = 16'hDEAD; op_b = 16'hBEEF; sub = ~s;
      if (push) begin
         e.res = r; e.cout = c; e.ovf = o; e.at = cyc + 4;
         sb.push_back(e);
      end
   endtask

   task automatic wait_idle();
      bit fin;
      fin = 0;
      for (int i = 0; i < 40 && !fin; i++) begin
         @(negedge clk); #1;
         if (sb.size() == 0 && ready) fin = 1;
      end
      check("drain_timeout", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      int unsigned prev;
      logic [15:0] ca [3];
      logic [15:0] cb [3];
      logic        cs [3];
      logic [15:0] cr [3];
      logic        cc [3];

      repeat (2) @(negedge clk);
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_flags", {30'd0, carry_out, overflow}, 32'd0);
      check("rst_adder", {23'd0, add_a, add_b, add_cin}, 32'd0);
      rst_n = 1'b1;

      start_op(16'h1234, 16'h0FFF, 1'b0, 1, 16'h2233, 1'b0, 1'b0);
      wait_idle();

      start_op(16'hFFFF, 16'h0001, 1'b0, 1, 16'h0000, 1'b1, 1'b0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("ripple_cin", 32'(add_cin), (k > 0) ? 32'd1 : 32'd0);
         if (k == 0) begin
            check("nib0_add_a", 32'(add_a), 32'hF);
            check("nib0_add_b", 32'(add_b), 32'h1);
         end
      end
      wait_idle();

      start_op(16'h7FFF, 16'h0001, 1'b0, 1, 16'h8000, 1'b0, 1'b1);
      wait_idle();
      start_op(16'h0005, 16'h0007, 1'b1, 1, 16'hFFFE, 1'b0, 1'b0);
      wait_idle();
      start_op(16'h8000, 16'h0001, 1'b1, 1, 16'h7FFF, 1'b1, 1'b1);
      wait_idle();

      start_op(16'h1234, 16'h0FFF, 1'b0, 1, 16'h2233, 1'b0, 1'b0);
      @(negedge clk);
      op_a = 16'h1111; op_b = 16'h1111; sub = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 10 && !done; i++) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      check("ignored_result", 32'(result), 32'h2233);
      check("ignored_ready", 32'(ready), 32'd1);
      wait_idle();

      ca = '{16'h0001, 16'h00FF, 16'hFFFF};
      cb = '{16'h0001, 16'h0001, 16'hFFFF};
      cs = '{1'b0, 1'b0, 1'b1};
      cr = '{16'h0002, 16'h0100, 16'h0000};
      cc = '{1'b0, 1'b0, 1'b1};
      prev = 0;
      @(negedge clk);
      start = 1'b1;
      for (int k = 0; k < 3; k++) begin
         exp_t e;
         bit   got;
         got = 0;
         for (int i = 0; i < 20 && !got; i++) begin
            if (ready) got = 1;
            else @(negedge clk);
         end
         op_a = ca[k]; op_b = cb[k]; sub = cs[k];
         @(posedge clk); #1;
         e.res = cr[k]; e.cout = cc[k]; e.ovf = 1'b0; e.at = cyc + 4;
         sb.push_back(e);
         if (k > 0) check("b2b_period", cyc - prev, 32'd6);
         prev = cyc;
         @(negedge clk);
      end
      start = 1'b0;
      wait_idle();

      start_op(16'h1234, 16'h0FFF, 1'b0, 0, 16'h0, 1'b0, 1'b0);
      @(posedge clk);
      @(posedge clk); #1;
      check("partial_result", 32'(result), 32'h0033);
      rst_n = 1'b0;
      #1;
      check("midrst_result", 32'(result), 32'd0);
      check("midrst_ready", 32'(ready), 32'd1);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_adder", {23'd0, add_a, add_b, add_cin}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      check("postrst_ready", 32'(ready), 32'd1);
      start_op(16'h0001, 16'h0002, 1'b0, 1, 16'h0003, 1'b0, 1'b0);
      wait_idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/nibble_serial_add_ctrl.md
# nibble_serial_add_ctrl

Multi-cycle controller that time-shares one external 4-bit ripple-carry adder to add or subtract two W-bit operands, one nibble per clock, least significant nibble first. It owns operand capture, nibble sequencing, the inter-nibble carry register, result assembly and flag generation. The top level wires its `add_*` ports straight to the team's 4-bit adder. Requesters use a start/ready/done handshake.

## Interface
- `NIBBLES`, default 4: number of 4-bit slices. Operand width W = 4*NIBBLES. Legal range 2..16.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request; sampled only when `ready`=1.
- `sub` input 1: 0 = A+B, 1 = A−B; captured with operands.
- `op_a` input W: operand A; captured on accepted start.
- `op_b` input W: operand B; captured on accepted start.
- `ready` output 1: high in IDLE only.
- `done` output 1: one-cycle pulse when the result is final.
- `result` output W: sum/difference; held until the next accepted start.
- `carry_out` output 1: final adder carry. For sub, 1 means no borrow.
- `overflow` output 1: two's-complement signed overflow.
- `add_a` output 4: adder operand A nibble.
- `add_b` output 4: adder operand B nibble, already inverted when `sub`=1.
- `add_cin` output 1: adder carry in.
- `add_sum` input 4: adder sum, combinational from `add_*`.
- `add_cout` input 1: adder carry out.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE → RUN on `start`=1.
  - RUN stays for NIBBLES cycles, then → DONE.
  - DONE → IDLE unconditionally.
- On an accepted start:
  - a_reg ← `op_a`.
  - b_reg ← `sub` ? ~`op_b` : `op_b`.
  - cy_reg ← `sub`.
  - idx ← 0.
  - `result`, `carry_out` and `overflow` are cleared to 0.
- During each RUN cycle:
  - `add_a` = a_reg[4*idx+3:4*idx], `add_b` = b_reg[same slice], `add_cin` = cy_reg.
  - At the edge: result[slice] ← `add_sum`, cy_reg ← `add_cout`, idx ← idx+1.
- Last nibble (idx = NIBBLES−1) at the edge:
  - `carry_out` ← `add_cout`.
  - `overflow` ← (a_msb == b_msb) && (`add_sum`[3] != a_msb), where the MSBs are taken from a_reg/b_reg (b after inversion).
  - State → DONE.
- Outside RUN, `add_a`, `add_b` and `add_cin` drive 0.
- `start` while `ready`=0 (RUN or DONE) is ignored; no queuing.
- Operands and `sub` may change freely after acceptance; only the captured copies are used.
- idx never wraps inside an operation; it resets to 0 on the next accept.

## Timing
- Reset (asynchronous, any state, including mid-RUN):
  - State = IDLE, so `ready`=1.
  - `done`=0, `result`=0, `carry_out`=0, `overflow`=0.
  - `add_a`=0, `add_b`=0, `add_cin`=0.
  - a_reg, b_reg, cy_reg and idx cleared.
  - Any in-flight operation is abandoned, with no `done`.
- Start accepted at edge E0. Nibble k is registered at edge E0+1+k.
- At edge E0+NIBBLES: final nibble and flags registered, state = DONE.
- `done`=1 for exactly the one cycle between edges E0+NIBBLES and E0+NIBBLES+1.
- `ready` rises at E0+NIBBLES+1.
- Throughput: one operation per NIBBLES+2 cycles with `start` held high continuously.
- The `result` partial nibbles are visible during RUN. Only values at/after `done` are architecturally valid.
- `done` is a registered output; `ready` is decoded from the state register. No combinational path from `start` to any output.
- The adder path is combinational `add_*` out → `add_sum`/`add_cout` in → register, within one clock.

## Test plan
All scenarios use NIBBLES=4.
- Plain add: `op_a`=0x1234, `op_b`=0x0FFF, `sub`=0 → `result`=0x2233, `carry_out`=0, `overflow`=0. `done` pulses exactly 4 cycles after the accept edge.
- Full carry ripple: `op_a`=0xFFFF + `op_b`=0x0001 → `result`=0x0000, `carry_out`=1, `overflow`=0. cy_reg=1 is observed on `add_cin` for nibbles 1–3.
- Signed overflow: `op_a`=0x7FFF + `op_b`=0x0001 → `result`=0x8000, `overflow`=1, `carry_out`=0.
- Subtract:
  - 0x0005 − 0x0007 → `result`=0xFFFE, `carry_out`=0, `overflow`=0.
  - 0x8000 − 0x0001 → `result`=0x7FFF, `carry_out`=1, `overflow`=1.
- Handshake:
  - `start` pulsed with `op_a`=0x1111 during RUN and DONE → ignored; the original result is unchanged.
  - `start` held high continuously → back-to-back operations with `done` every 6 cycles.
- Reset mid-RUN: `rst_n` low after 2 nibbles → immediately `result`=0, `ready`=1, no `done`. A fresh op 0x0001+0x0002 then gives 0x0003.
